// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX issue register; decodes MIPS instructions into ALUFun code and operands.
// Ports: clk/reset (sync, active-high); in_valid/in_ready + instr/rs_data/rt_data from decode;
//        flush kills held entry and same-cycle accept; ex_valid/ex_ready handshake to execute;
//        ex_alufun/ex_a/ex_b/ex_sign/ex_dest/ex_reg_write/ex_mem_rd/ex_mem_wr/ex_branch/ex_illegal.
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [5:0]  ex_alufun,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic        ex_sign,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        ex_mem_rd,
    output logic        ex_mem_wr,
    output logic        ex_branch,
    output logic        ex_illegal
);
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND = 6'b011000, OR = 6'b011110,
                           XOR = 6'b010110, NOR = 6'b010001, SLL = 6'b100000, SRL = 6'b100001,
                           SRA = 6'b100011, EQ = 6'b110011, NEQ = 6'b110001, LT = 6'b110101,
                           LEZ = 6'b111101, LTZ = 6'b111011, GTZ = 6'b111111;
    typedef struct packed {
        logic [5:0]  alufun;
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        illegal;
    } entry_t;
    entry_t dec, entry_d, entry_q;
    logic valid_d, valid_q;
    logic [5:0] op, funct;
    logic [4:0] rt, rd, shamt;
    logic [31:0] sx, zx;
    assign op    = instr[31:26];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];
    assign funct = instr[5:0];
    assign sx    = {{16{instr[15]}}, instr[15:0]};
    assign zx    = {16'b0, instr[15:0]};
    always_comb begin
        dec      = '0;
        dec.a    = rs_data;
        dec.b    = rt_data;
        dec.sign = 1'b1;
        dec.dest = rt;
        case (op)
            6'h00: begin
                dec.dest      = rd;
                dec.reg_write = 1'b1;
                case (funct)
                    6'h20: dec.alufun = ADD;
                    6'h21: begin dec.alufun = ADD; dec.sign = 1'b0; end
                    6'h22: dec.alufun = SUB;
                    6'h23: begin dec.alufun = SUB; dec.sign = 1'b0; end
                    6'h24: dec.alufun = AND;
                    6'h25: dec.alufun = OR;
                    6'h26: dec.alufun = XOR;
                    6'h27: dec.alufun = NOR;
                    6'h2A: dec.alufun = LT;
                    6'h2B: begin dec.alufun = LT; dec.sign = 1'b0; end
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                        // Shifts put the shifted value in A and the amount in B.
                        dec.a      = rt_data;
                        dec.b      = {27'b0, funct[2] ? rs_data[4:0] : shamt};
                        dec.alufun = funct[1:0] == 2'b00 ? SLL : funct[0] ? SRA : SRL;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h08: begin dec.b = sx; dec.reg_write = 1'b1; end
            6'h09: begin dec.b = sx; dec.reg_write = 1'b1; dec.sign = 1'b0; end
            6'h0A: begin dec.b = sx; dec.reg_write = 1'b1; dec.alufun = LT; end
            6'h0B: begin dec.b = sx; dec.reg_write = 1'b1; dec.alufun = LT; dec.sign = 1'b0; end
            6'h0C: begin dec.b = zx; dec.reg_write = 1'b1; dec.alufun = AND; end
            6'h0D: begin dec.b = zx; dec.reg_write = 1'b1; dec.alufun = OR; end
            6'h0E: begin dec.b = zx; dec.reg_write = 1'b1; dec.alufun = XOR; end
            6'h0F: begin dec.a = {instr[15:0], 16'b0}; dec.b = '0; dec.reg_write = 1'b1; end
            6'h23: begin dec.b = sx; dec.reg_write = 1'b1; dec.mem_rd = 1'b1; end
            6'h2B: begin dec.b = sx; dec.mem_wr = 1'b1; end
            6'h04: begin dec.branch = 1'b1; dec.alufun = EQ; end
            6'h05: begin dec.branch = 1'b1; dec.alufun = NEQ; end
            6'h06: begin dec.branch = 1'b1; dec.alufun = LEZ; end
            6'h07: begin dec.branch = 1'b1; dec.alufun = GTZ; end
            6'h01: begin dec.branch = 1'b1; dec.alufun = LTZ; dec.illegal = rt != 5'd0; end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal entries still issue but must be harmless: ADD of zeros, no side effects.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end
    assign in_ready = !valid_q || ex_ready;
    always_comb begin
        valid_d = valid_q && !ex_ready;
        entry_d = entry_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            valid_d = 1'b1;
            entry_d = dec;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end
    assign ex_valid     = valid_q;
    assign ex_alufun    = entry_q.alufun;
    assign ex_a         = entry_q.a;
    assign ex_b         = entry_q.b;
    assign ex_sign      = entry_q.sign;
    assign ex_dest      = entry_q.dest;
    assign ex_reg_write = entry_q.reg_write;
    assign ex_mem_rd    = entry_q.mem_rd;
    assign ex_mem_wr    = entry_q.mem_wr;
    assign ex_branch    = entry_q.branch;
    assign ex_illegal   = entry_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, ex_ready = 1'b1;
    logic [31:0] instr = '0, rs_data = '0, rt_data = '0;
    logic in_ready, ex_valid, ex_sign, ex_reg_write, ex_mem_rd, ex_mem_wr, ex_branch, ex_illegal;
    logic [5:0] ex_alufun;
    logic [31:0] ex_a, ex_b;
    logic [4:0] ex_dest;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    alu_issue_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .ex_alufun(ex_alufun), .ex_a(ex_a), .ex_b(ex_b), .ex_sign(ex_sign),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_rd(ex_mem_rd),
        .ex_mem_wr(ex_mem_wr), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
        instr = i; rs_data = rs; rt_data = rt; in_valid = 1'b1;
        step();
    endtask
    initial begin
        step();
        step();
        chk("rst_valid", ex_valid, 0);
        chk("rst_alufun", ex_alufun, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_a", ex_a, 0);
        chk("rst_sign", ex_sign, 0);
        reset = 1'b0;
        issue(32'h00221820, 5, 7);
        chk("add_valid", ex_valid, 1);
        chk("add_alufun", ex_alufun, 6'b000000);
        chk("add_a", ex_a, 5);
        chk("add_b", ex_b, 7);
        chk("add_dest", ex_dest, 3);
        chk("add_rw", ex_reg_write, 1);
        chk("add_sign", ex_sign, 1);
        issue(32'h000520C3, 32'h11, 32'h80000000);
        chk("sra_alufun", ex_alufun, 6'b100011);
        chk("sra_a", ex_a, 32'h80000000);
        chk("sra_b", ex_b, 3);
        chk("sra_dest", ex_dest, 4);
        issue(32'h2022FFFF, 5, 9);
        chk("addi_b", ex_b, 32'hFFFFFFFF);
        chk("addi_sign", ex_sign, 1);
        chk("addi_alufun", ex_alufun, 6'b000000);
        chk("addi_dest", ex_dest, 2);
        issue(32'h3422FFFF, 5, 9);
        chk("ori_b", ex_b, 32'h0000FFFF);
        chk("ori_alufun", ex_alufun, 6'b011110);
        issue(32'h0022182B, 9, 4);
        chk("sltu_alufun", ex_alufun, 6'b110101);
        chk("sltu_sign", ex_sign, 0);
        issue(32'h3C011234, 5, 9);
        chk("lui_a", ex_a, 32'h12340000);
        chk("lui_b", ex_b, 0);
        issue(32'h8C220010, 5, 9);
        chk("lw_memrd", ex_mem_rd, 1);
        chk("lw_b", ex_b, 32'h10);
        chk("lw_rw", ex_reg_write, 1);
        issue(32'hAC220010, 5, 9);
        chk("sw_memwr", ex_mem_wr, 1);
        chk("sw_rw", ex_reg_write, 0);
        issue(32'h10220004, 3, 3);
        chk("beq_alufun", ex_alufun, 6'b110011);
        chk("beq_branch", ex_branch, 1);
        chk("beq_rw", ex_reg_write, 0);
        chk("beq_b", ex_b, 3);
        issue(32'h04200004, 3, 0);
        chk("bltz_alufun", ex_alufun, 6'b111011);
        chk("bltz_illegal", ex_illegal, 0);
        issue(32'h04210004, 3, 0);
        chk("op1_illegal", ex_illegal, 1);
        chk("op1_branch", ex_branch, 0);
        issue(32'h00221804, 32'h23, 5);
        chk("sllv_alufun", ex_alufun, 6'b100000);
        chk("sllv_a", ex_a, 5);
        chk("sllv_b", ex_b, 3);
        issue(32'h00221820, 1, 2);
        ex_ready = 1'b0;
        instr = 32'h00221826; rs_data = 32'hF0; rt_data = 32'h0F;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", ex_valid, 1);
            chk("stall_a", ex_a, 1);
            chk("stall_alufun", ex_alufun, 6'b000000);
            chk("stall_in_ready", in_ready, 0);
        end
        ex_ready = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1);
        step();
        chk("xor_alufun", ex_alufun, 6'b010110);
        chk("xor_a", ex_a, 32'hF0);
        chk("xor_valid", ex_valid, 1);
        in_valid = 1'b0;
        step();
        chk("drain_valid", ex_valid, 0);
        chk("drain_in_ready", in_ready, 1);
        issue(32'h00221820, 5, 7);
        ex_ready = 1'b0; flush = 1'b1;
        instr = 32'h3422FFFF;
        step();
        chk("flush_valid", ex_valid, 0);
        chk("flush_hold_alufun", ex_alufun, 6'b000000);
        chk("flush_hold_b", ex_b, 7);
        flush = 1'b0; ex_ready = 1'b1;
        issue(32'hFC000000, 5, 7);
        chk("ill_flag", ex_illegal, 1);
        chk("ill_a", ex_a, 0);
        chk("ill_b", ex_b, 0);
        chk("ill_rw", ex_reg_write, 0);
        chk("ill_alufun", ex_alufun, 0);
        chk("ill_valid", ex_valid, 1);
        issue(32'h3422FFFF, 5, 7);
        reset = 1'b1; flush = 1'b1;
        step();
        chk("midrst_valid", ex_valid, 0);
        chk("midrst_alufun", ex_alufun, 0);
        chk("midrst_b", ex_b, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
